// File: rtl/key_event_pkg.sv
// Shared types and 50 MHz board timing defaults for the key event block.
package key_event_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } key_state_t;

   localparam int CNT_W_DEF         = 26;
   localparam int LONG_DELAY_DEF    = 25_000_000;
   localparam int REPEAT_PERIOD_DEF = 5_000_000;

endpackage

// File: rtl/key_event.sv
// Turns a debounced key level into registered one-cycle press/release/click/
// long-press/repeat pulses plus a registered held level.
module key_event
   import key_event_pkg::*;
#(
   parameter int CNT_W         = CNT_W_DEF,
   parameter int LONG_DELAY    = LONG_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_press,
   output logic       press,
   // release/repeat are reserved words, hence the _pulse suffix
   output logic       release_pulse,
   output logic       click,
   output logic       long_press,
   output logic       repeat_pulse,
   output logic       held,
   output key_state_t state
);

   if (LONG_DELAY < 2 || 64'(LONG_DELAY) > (64'd1 << CNT_W)) begin : g_bad_long_delay
      $fatal(1, "key_event: LONG_DELAY out of range");
   end
   if (REPEAT_PERIOD < 2 || 64'(REPEAT_PERIOD) > (64'd1 << CNT_W)) begin : g_bad_repeat_period
      $fatal(1, "key_event: REPEAT_PERIOD out of range");
   end

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

   logic             prev_key;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             fall;

   assign rise = key_press & ~prev_key;
   assign fall = ~key_press & prev_key;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         prev_key      <= 1'b0;
         cnt           <= '0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         click         <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         held          <= 1'b0;
      end else begin
         prev_key      <= key_press;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         click         <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               held <= 1'b0;
               if (rise) begin
                  press <= 1'b1;
                  cnt   <= '0;
                  held  <= 1'b1;
                  state <= PRESSED;
               end
            end
            PRESSED: begin
               // A fall on the terminal edge takes priority over long_press
               if (fall) begin
                  release_pulse <= 1'b1;
                  click         <= 1'b1;
                  held          <= 1'b0;
                  state         <= IDLE;
               end else if (cnt == LONG_LAST) begin
                  long_press <= 1'b1;
                  cnt        <= '0;
                  state      <= REPEAT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            REPEAT: begin
               if (fall) begin
                  release_pulse <= 1'b1;
                  held          <= 1'b0;
                  state         <= IDLE;
               end else if (cnt == REP_LAST) begin
                  repeat_pulse <= 1'b1;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               held  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: elapsed-time reference model checked every
// cycle, plus literal event-timing expectations per scenario.
module tb_key_event;
   import key_event_pkg::*;

   localparam int CNT_W = 4;
   localparam int LD    = 8;
   localparam int RP    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_press = 1'b0;
   logic       press, release_pulse, click, long_press, repeat_pulse, held;
   key_state_t state;

   key_event #(.CNT_W(CNT_W), .LONG_DELAY(LD), .REPEAT_PERIOD(RP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_press     (key_press),
      .press         (press),
      .release_pulse (release_pulse),
      .click         (click),
      .long_press    (long_press),
      .repeat_pulse  (repeat_pulse),
      .held          (held),
      .state         (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks how long the key has been down, in edges.
   logic m_pressed, m_long, m_prev;
   int   m_hold;
   logic e_press, e_rel, e_click, e_long, e_rep;

   always @(posedge clk or negedge rst_n) begin : model
      logic p, l;
      int   h;
      logic ep, er, ec, el, erp;
      if (!rst_n) begin
         m_pressed <= 1'b0; m_long <= 1'b0; m_prev <= 1'b0; m_hold <= 0;
         e_press <= 1'b0; e_rel <= 1'b0; e_click <= 1'b0;
         e_long <= 1'b0; e_rep <= 1'b0;
      end else begin
         p = m_pressed; l = m_long; h = m_hold;
         ep = 1'b0; er = 1'b0; ec = 1'b0; el = 1'b0; erp = 1'b0;
         if (!p && key_press && !m_prev) begin
            ep = 1'b1; p = 1'b1; l = 1'b0; h = 0;
         end else if (p && !key_press && m_prev) begin
            er = 1'b1; ec = !l; p = 1'b0;
         end else if (p) begin
            h = h + 1;
            if (h == LD) begin
               el = 1'b1; l = 1'b1;
            end else if (h > LD && ((h - LD) % RP) == 0) begin
               erp = 1'b1;
            end
         end
         m_pressed <= p; m_long <= l; m_hold <= h; m_prev <= key_press;
         e_press <= ep; e_rel <= er; e_click <= ec; e_long <= el; e_rep <= erp;
      end
   end

   key_state_t e_state;
   always_comb begin
      e_state = IDLE;
      if (m_pressed) e_state = m_long ? REPEAT : PRESSED;
   end

   bit check_en = 1'b0;
   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_press", int'(press), int'(e_press));
         chk("cyc_release", int'(release_pulse), int'(e_rel));
         chk("cyc_click", int'(click), int'(e_click));
         chk("cyc_long", int'(long_press), int'(e_long));
         chk("cyc_repeat", int'(repeat_pulse), int'(e_rep));
         chk("cyc_held", int'(held), int'(m_pressed));
         chk("cyc_state", int'(state), int'(e_state));
      end
   end

   // Event log: edge number of the posedge that produced each pulse.
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int press_n, rel_n, click_n, long_n;
   int press_edge, rel_edge, long_edge;
   int rep_q[$];

   task automatic clear_log();
      press_n = 0; rel_n = 0; click_n = 0; long_n = 0;
      press_edge = -1; rel_edge = -1; long_edge = -1;
      rep_q.delete();
   endtask

   always @(negedge clk) begin
      if (press)         begin press_n++; press_edge = edge_cnt; end
      if (release_pulse) begin rel_n++;   rel_edge   = edge_cnt; end
      if (click)         click_n++;
      if (long_press)    begin long_n++;  long_edge  = edge_cnt; end
      if (repeat_pulse)  rep_q.push_back(edge_cnt);
   end

   task automatic drive(input logic v);
      @(negedge clk);
      key_press = v;
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) drive(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   int t0;

   initial begin
      clear_log();
      #1;
      chk("reset_press", int'(press), 0);
      chk("reset_held", int'(held), 0);
      chk("reset_state", int'(state), int'(IDLE));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_en = 1'b1;
      hold(0, 2);

      // Short tap: high on t0..t0+2, low on t0+3
      clear_log();
      drive(1); t0 = edge_cnt + 1;
      hold(1, 2);
      hold(0, 4);
      chk("tap_press_edge", press_edge, t0);
      chk("tap_release_edge", rel_edge, t0 + 3);
      chk("tap_click_n", click_n, 1);
      chk("tap_long_n", long_n, 0);
      chk("tap_repeat_n", rep_q.size(), 0);

      // Long hold: low on t0+17
      clear_log();
      drive(1); t0 = edge_cnt + 1;
      hold(1, 16);
      hold(0, 4);
      chk("long_long_edge", long_edge, t0 + 8);
      chk("long_repeat_n", rep_q.size(), 2);
      if (rep_q.size() == 2) begin
         chk("long_repeat0_edge", rep_q[0], t0 + 12);
         chk("long_repeat1_edge", rep_q[1], t0 + 16);
      end
      chk("long_release_edge", rel_edge, t0 + 17);
      chk("long_click_n", click_n, 0);

      // Tie at long_press terminal: low exactly on t0+8
      clear_log();
      drive(1); t0 = edge_cnt + 1;
      hold(1, 7);
      hold(0, 4);
      chk("tie_release_edge", rel_edge, t0 + 8);
      chk("tie_click_n", click_n, 1);
      chk("tie_long_n", long_n, 0);

      // Tie at first repeat terminal: low exactly on t0+12
      clear_log();
      drive(1); t0 = edge_cnt + 1;
      hold(1, 11);
      hold(0, 4);
      chk("rtie_long_edge", long_edge, t0 + 8);
      chk("rtie_release_edge", rel_edge, t0 + 12);
      chk("rtie_repeat_n", rep_q.size(), 0);
      chk("rtie_click_n", click_n, 0);

      // Reset mid-hold with key still down
      clear_log();
      drive(1); t0 = edge_cnt + 1;
      hold(1, 9);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_held", int'(held), 0);
      chk("mid_rst_long", int'(long_press), 0);
      chk("mid_rst_state", int'(state), int'(IDLE));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      t0 = edge_cnt + 1;
      hold(1, 9);
      hold(0, 4);
      chk("rst_repress_edge", press_edge, t0);
      chk("rst_long_edge", long_edge, t0 + 8);

      // Back-to-back taps alternating every edge
      clear_log();
      drive(1); t0 = edge_cnt + 1;
      drive(0); drive(1); drive(0); drive(1); drive(0);
      hold(0, 3);
      chk("b2b_press_n", press_n, 3);
      chk("b2b_release_n", rel_n, 3);
      chk("b2b_click_n", click_n, 3);
      chk("b2b_last_release_edge", rel_edge, t0 + 5);
      chk("b2b_long_n", long_n, 0);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
